// File: rtl/ariane_timer_sched_if.sv
// APB master bundle carrying the mtimecmp write from the scheduler to the timer.
interface ariane_timer_sched_if #(
   parameter int unsigned ADDR_W = 12
);
   logic [ADDR_W-1:0] PADDR;
   logic [63:0]       PWDATA;
   logic              PWRITE;
   logic              PSEL;
   logic              PENABLE;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      input  PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      output PREADY, PSLVERR
   );
endinterface

// File: rtl/ariane_timer_sched.sv
// Virtual timer scheduler: multiplexes NR_TIMERS software deadlines onto a
// single hardware mtimecmp, rewritten over APB with the earliest armed deadline.
// Optional: ARIANE_TIMER_SCHED_SKIP_REDUNDANT_EN suppresses writes whose value
// matches the last successfully programmed one.
module ariane_timer_sched #(
   parameter int unsigned               NR_TIMERS      = 4,
   parameter int unsigned               APB_ADDR_WIDTH = 12,
   parameter logic [APB_ADDR_WIDTH-1:0] CMP_ADDR       = 12'h400
) (
   input  logic                         HCLK,
   input  logic                         HRESET,
   input  logic [63:0]                  time_i,
   input  logic                         set_valid_i,
   input  logic [$clog2(NR_TIMERS)-1:0] set_id_i,
   input  logic [63:0]                  set_deadline_i,
   input  logic                         cancel_valid_i,
   input  logic [$clog2(NR_TIMERS)-1:0] cancel_id_i,
   output logic [NR_TIMERS-1:0]         expired_o,
   output logic [NR_TIMERS-1:0]         armed_o,
   output logic                         err_o,
   output logic                         busy_o,
   ariane_timer_sched_if.master         apb
);

   localparam int unsigned ID_W    = $clog2(NR_TIMERS);
   localparam logic [63:0] MAX_DL  = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SCAN      = 2'd1,
      WR_SETUP  = 2'd2,
      WR_ACCESS = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [NR_TIMERS-1:0]      r_armed;
   logic [NR_TIMERS-1:0]      r_expired;
   logic [63:0]               r_deadline [NR_TIMERS];
   logic                      r_dirty;
   logic [ID_W-1:0]           r_idx;
   logic [63:0]               r_min;
   logic                      r_err;
   logic                      r_busy;
   logic                      r_psel;
   logic                      r_penable;
   logic                      r_pwrite;
   logic [APB_ADDR_WIDTH-1:0] r_paddr;
   logic [63:0]               r_pwdata;

   logic [NR_TIMERS-1:0]      w_set_hit;
   logic [NR_TIMERS-1:0]      w_cancel_hit;
   logic [NR_TIMERS-1:0]      w_exp_hit;
   logic                      w_event;
   logic                      w_enter_scan;
   logic                      w_scan_last;
   logic                      w_wr_done;
   logic [63:0]               w_min_next;

`ifdef ARIANE_TIMER_SCHED_SKIP_REDUNDANT_EN
   logic [63:0]               r_programmed;
`endif

   // Per-timer decode of set/cancel strobes and expiry condition.
   always_comb begin
      w_set_hit    = '0;
      w_cancel_hit = '0;
      w_exp_hit    = '0;
      for (int i = 0; i < NR_TIMERS; i++) begin
         w_set_hit[i]    = set_valid_i && (set_id_i == ID_W'(i));
         w_cancel_hit[i] = cancel_valid_i && (cancel_id_i == ID_W'(i));
         w_exp_hit[i]    = r_armed[i] && (time_i >= r_deadline[i]);
      end
   end

   assign w_event      = (|w_set_hit) || (|w_cancel_hit) || (|w_exp_hit);
   assign w_enter_scan = (r_state == IDLE) && r_dirty;
   assign w_scan_last  = (r_idx == ID_W'(NR_TIMERS - 1));
   assign w_wr_done    = (r_state == WR_ACCESS) && apb.PREADY;

   // Running minimum including the timer visited this cycle; strict compare keeps the lowest index on ties.
   always_comb begin
      w_min_next = r_min;
      if (r_armed[r_idx] && (r_deadline[r_idx] < r_min)) begin
         w_min_next = r_deadline[r_idx];
      end
   end

   // Timer array: set beats cancel beats expiry on the same index.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_armed   <= '0;
         r_expired <= '0;
         for (int i = 0; i < NR_TIMERS; i++) begin
            r_deadline[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NR_TIMERS; i++) begin
            r_expired[i] <= 1'b0;
            if (w_set_hit[i]) begin
               r_armed[i]    <= 1'b1;
               r_deadline[i] <= set_deadline_i;
            end else if (w_cancel_hit[i]) begin
               r_armed[i] <= 1'b0;
            end else if (w_exp_hit[i]) begin
               r_armed[i]   <= 1'b0;
               r_expired[i] <= 1'b1;
            end
         end
      end
   end

   // FSM state register.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (r_dirty) begin
               w_state_next = SCAN;
            end
         end
         SCAN: begin
            if (w_scan_last) begin
`ifdef ARIANE_TIMER_SCHED_SKIP_REDUNDANT_EN
               if ((w_min_next == r_programmed) && !r_err) begin
                  w_state_next = IDLE;
               end else begin
                  w_state_next = WR_SETUP;
               end
`else
               w_state_next = WR_SETUP;
`endif
            end
         end
         WR_SETUP: begin
            w_state_next = WR_ACCESS;
         end
         WR_ACCESS: begin
            if (apb.PREADY) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Rescan request: new events and failed writes win over the clear on scan entry.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_dirty <= 1'b1;
      end else if (w_event || (w_wr_done && apb.PSLVERR)) begin
         r_dirty <= 1'b1;
      end else if (w_enter_scan) begin
         r_dirty <= 1'b0;
      end
   end

   // Scan index and minimum accumulator.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_idx <= '0;
         r_min <= MAX_DL;
      end else if (w_enter_scan) begin
         r_idx <= '0;
         r_min <= MAX_DL;
      end else if (r_state == SCAN) begin
         r_idx <= r_idx + ID_W'(1);
         r_min <= w_min_next;
      end
   end

   // Sticky slave-error flag.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_err <= 1'b0;
      end else if (w_wr_done && apb.PSLVERR) begin
         r_err <= 1'b1;
      end
   end

`ifdef ARIANE_TIMER_SCHED_SKIP_REDUNDANT_EN
   // Last value accepted by the timer, used to skip redundant writes.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_programmed <= '0;
      end else if (w_wr_done && !apb.PSLVERR) begin
         r_programmed <= r_min;
      end
   end
`endif

   // Registered APB request and busy flag, derived from the upcoming state.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_pwrite  <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= '0;
         r_busy    <= 1'b0;
      end else begin
         r_busy <= (w_state_next != IDLE);
         case (w_state_next)
            WR_SETUP: begin
               r_psel    <= 1'b1;
               r_penable <= 1'b0;
               r_pwrite  <= 1'b1;
               r_paddr   <= CMP_ADDR;
               r_pwdata  <= w_min_next;
            end
            WR_ACCESS: begin
               r_psel    <= 1'b1;
               r_penable <= 1'b1;
               r_pwrite  <= 1'b1;
               r_paddr   <= CMP_ADDR;
               r_pwdata  <= r_pwdata;
            end
            default: begin
               r_psel    <= 1'b0;
               r_penable <= 1'b0;
               r_pwrite  <= 1'b0;
               r_paddr   <= '0;
               r_pwdata  <= '0;
            end
         endcase
      end
   end

   assign apb.PSEL    = r_psel;
   assign apb.PENABLE = r_penable;
   assign apb.PWRITE  = r_pwrite;
   assign apb.PADDR   = r_paddr;
   assign apb.PWDATA  = r_pwdata;

   assign expired_o = r_expired;
   assign armed_o   = r_armed;
   assign err_o     = r_err;
   assign busy_o    = r_busy;

endmodule

// File: tb/tb_ariane_timer_sched.sv
// Directed self-checking bench for ariane_timer_sched (NR_TIMERS=4).
module tb_ariane_timer_sched;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic [63:0] time_i;
   logic        set_valid_i;
   logic [1:0]  set_id_i;
   logic [63:0] set_deadline_i;
   logic        cancel_valid_i;
   logic [1:0]  cancel_id_i;
   logic [3:0]  expired_o;
   logic [3:0]  armed_o;
   logic        err_o;
   logic        busy_o;

   ariane_timer_sched_if #(.ADDR_W(12)) apb ();

   ariane_timer_sched #(
      .NR_TIMERS      (4),
      .APB_ADDR_WIDTH (12),
      .CMP_ADDR       (12'h400)
   ) dut (
      .HCLK           (HCLK),
      .HRESET         (HRESET),
      .time_i         (time_i),
      .set_valid_i    (set_valid_i),
      .set_id_i       (set_id_i),
      .set_deadline_i (set_deadline_i),
      .cancel_valid_i (cancel_valid_i),
      .cancel_id_i    (cancel_id_i),
      .expired_o      (expired_o),
      .armed_o        (armed_o),
      .err_o          (err_o),
      .busy_o         (busy_o),
      .apb            (apb)
   );

   always #5 HCLK = ~HCLK;

   int          total = 0;
   int          bad   = 0;
   int          wr_cnt = 0;
   int          psel_cnt = 0;
   logic [63:0] wr_data = '0;
   logic [11:0] wr_addr = '0;

   // Completed-transfer monitor (error completions are counted too).
   always @(posedge HCLK) begin
      if (apb.PSEL && apb.PENABLE && apb.PREADY) begin
         wr_cnt  <= wr_cnt + 1;
         wr_data <= apb.PWDATA;
         wr_addr <= apb.PADDR;
      end
      if (apb.PSEL) psel_cnt <= psel_cnt + 1;
   end

   task automatic tick;
      @(posedge HCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_set(input logic [1:0] id, input logic [63:0] dl);
      set_valid_i    = 1'b1;
      set_id_i       = id;
      set_deadline_i = dl;
      tick;
      set_valid_i    = 1'b0;
   endtask

   task automatic do_cancel(input logic [1:0] id);
      cancel_valid_i = 1'b1;
      cancel_id_i    = id;
      tick;
      cancel_valid_i = 1'b0;
   endtask

   // Wait for three consecutive idle cycles; reports whether busy was seen.
   task automatic settle(input string tag, output logic seen);
      int lows;
      lows = 0;
      seen = 1'b0;
      for (int c = 0; c < 300 && lows < 3; c++) begin
         tick;
         if (busy_o) begin
            seen = 1'b1;
            lows = 0;
         end else begin
            lows++;
         end
      end
      chk(tag, 64'(lows >= 3), 64'd1);
   endtask

   task automatic wait_write(input int n0, input string tag);
      for (int c = 0; c < 200 && wr_cnt <= n0; c++) tick;
      chk(tag, 64'(wr_cnt > n0), 64'd1);
   endtask

   task automatic wait_psel(input string tag);
      for (int c = 0; c < 100 && !(apb.PSEL && apb.PENABLE); c++) tick;
      chk(tag, 64'(apb.PSEL && apb.PENABLE), 64'd1);
   endtask

   logic seen;
   int   n0;
   int   p0;

   initial begin
      HRESET         = 1'b1;
      time_i         = 64'd0;
      set_valid_i    = 1'b0;
      set_id_i       = 2'd0;
      set_deadline_i = 64'd0;
      cancel_valid_i = 1'b0;
      cancel_id_i    = 2'd0;
      apb.PREADY     = 1'b1;
      apb.PSLVERR    = 1'b0;

      // Reset state
      tick; tick; tick;
      chk("rst_psel",    64'(apb.PSEL),    64'd0);
      chk("rst_penable", 64'(apb.PENABLE), 64'd0);
      chk("rst_pwdata",  apb.PWDATA,       64'd0);
      chk("rst_armed",   64'(armed_o),     64'd0);
      chk("rst_expired", 64'(expired_o),   64'd0);
      chk("rst_err",     64'(err_o),       64'd0);
      chk("rst_busy",    64'(busy_o),      64'd0);

      // Initial write of all-ones after reset release
      HRESET = 1'b0;
      wait_write(0, "init_wr_timeout");
      chk("init_wr_data",  wr_data,       64'hFFFF_FFFF_FFFF_FFFF);
      chk("init_wr_addr",  64'(wr_addr),  64'h400);
      chk("init_armed",    64'(armed_o),  64'd0);
      settle("init_settle", seen);

      // Two timers armed: earliest deadline programmed
      time_i = 64'd100;
      do_set(2'd1, 64'd500);
      do_set(2'd2, 64'd300);
      settle("two_settle", seen);
      chk("two_wr_data", wr_data,      64'd300);
      chk("two_armed",   64'(armed_o), 64'h6);

      // Time reaches 300: timer 2 pulses for one cycle, then 500 programmed
      time_i = 64'd300;
      tick;
      chk("exp2_pulse",  64'(expired_o), 64'h4);
      chk("exp2_armed",  64'(armed_o),   64'h2);
      tick;
      chk("exp2_end",    64'(expired_o), 64'h0);
      settle("exp2_settle", seen);
      chk("exp2_wr_data", wr_data,       64'd500);

      // Deadline already in the past: pulse two cycles after the strobe
      do_set(2'd0, 64'd50);
      chk("past_no_pulse", 64'(expired_o), 64'h0);
      chk("past_armed",    64'(armed_o),   64'h3);
      tick;
      chk("past_pulse",    64'(expired_o), 64'h1);
      chk("past_disarm",   64'(armed_o),   64'h2);
      tick;
      chk("past_end",      64'(expired_o), 64'h0);
      settle("past_settle", seen);
      chk("past_wr_data",  wr_data,        64'd500);

      // Set and cancel same id in one cycle: set wins
      set_valid_i    = 1'b1;
      set_id_i       = 2'd3;
      set_deadline_i = 64'd900;
      cancel_valid_i = 1'b1;
      cancel_id_i    = 2'd3;
      tick;
      set_valid_i    = 1'b0;
      cancel_valid_i = 1'b0;
      chk("setcan_armed", 64'(armed_o), 64'hA);
      settle("setcan_settle", seen);
      chk("setcan_wr_data", wr_data, 64'd500);
      do_cancel(2'd1);
      settle("can1_settle", seen);
      chk("can1_wr_data", wr_data,      64'd900);
      chk("can1_armed",   64'(armed_o), 64'h8);

      // Cancel of a non-minimum timer
      do_set(2'd2, 64'd2000);
      settle("nonmin_set_settle", seen);
      p0 = psel_cnt;
      n0 = wr_cnt;
      do_cancel(2'd2);
      settle("nonmin_settle", seen);
      chk("nonmin_scan_ran", 64'(seen), 64'd1);
`ifdef ARIANE_TIMER_SCHED_SKIP_REDUNDANT_EN
      chk("nonmin_no_psel", 64'(psel_cnt - p0), 64'd0);
`else
      chk("nonmin_wr_cnt",  64'(wr_cnt - n0),   64'd1);
      chk("nonmin_wr_data", wr_data,            64'd900);
`endif

      // Stalled completer then slave error: request stable, error sticky, retry identical
      apb.PREADY = 1'b0;
      do_set(2'd1, 64'd700);
      wait_psel("stall_wait");
      for (int k = 0; k < 5; k++) begin
         chk("stall_stable",
             64'({apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR == 12'h400, apb.PWDATA == 64'd700}),
             64'h1F);
         tick;
      end
      apb.PREADY  = 1'b1;
      apb.PSLVERR = 1'b1;
      tick;
      apb.PSLVERR = 1'b0;
      chk("slverr_err", 64'(err_o), 64'd1);
      n0 = wr_cnt;
      wait_write(n0, "retry_timeout");
      chk("retry_wr_data", wr_data,     64'd700);
      chk("retry_wr_addr", 64'(wr_addr), 64'h400);
      settle("retry_settle", seen);
      chk("retry_err_sticky", 64'(err_o), 64'd1);

      // Reset in the middle of a transfer
      apb.PREADY = 1'b0;
      do_set(2'd0, 64'd1000);
      wait_psel("midrst_wait");
      HRESET = 1'b1;
      tick;
      chk("midrst_psel",  64'(apb.PSEL), 64'd0);
      chk("midrst_busy",  64'(busy_o),   64'd0);
      chk("midrst_armed", 64'(armed_o),  64'd0);
      chk("midrst_err",   64'(err_o),    64'd0);
      HRESET     = 1'b0;
      apb.PREADY = 1'b1;
      n0 = wr_cnt;
      wait_write(n0, "midrst_wr_timeout");
      chk("midrst_wr_data", wr_data, 64'hFFFF_FFFF_FFFF_FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ariane_timer_sched.md
ARIANE_TIMER_SCHED -- requirements
Module: ariane_timer_sched

Interface
REQ-001 Parameter NR_TIMERS, default 4, number of virtual timers multiplexed onto one hardware mtimecmp (legal 2..16).
REQ-002 Parameter APB_ADDR_WIDTH, default 12, width of the APB master address.
REQ-003 Parameter CMP_ADDR, default 12'h400, APB address of the target mtimecmp register.
REQ-004 HCLK  in  1  sole clock; all state changes on its rising edge.
REQ-005 HRESET  in  1  reset, synchronous, active-high.
REQ-006 time_i  in  64  current mtime from the timer's time output.
REQ-007 set_valid_i  in  1  strobe: arm timer set_id_i with set_deadline_i.
REQ-008 set_id_i  in  $clog2(NR_TIMERS)  timer index for set.
REQ-009 set_deadline_i  in  64  absolute deadline in mtime ticks.
REQ-010 cancel_valid_i  in  1  strobe: disarm timer cancel_id_i.
REQ-011 cancel_id_i  in  $clog2(NR_TIMERS)  timer index for cancel.
REQ-012 expired_o  out  NR_TIMERS  one-cycle pulse per timer on expiry.
REQ-013 armed_o  out  NR_TIMERS  current armed flags.
REQ-014 PADDR, PWDATA(64), PWRITE, PSEL, PENABLE  out  APB master request signals.
REQ-015 PREADY, PSLVERR  in  1 each  APB completer response.
REQ-016 err_o  out  1  sticky: an APB write returned PSLVERR.
REQ-017 busy_o  out  1  high whenever FSM is not IDLE.

Function
REQ-018 Per timer: armed_q flag, 64-bit deadline_q; set writes deadline and sets armed (overwrite if already armed); cancel clears armed.
REQ-019 Expiry: at each edge, any armed i with time_i >= deadline_q[i] (unsigned) clears armed_q[i] and drives expired_o[i]=1 for exactly the next cycle.
REQ-020 Simultaneous on same id: set beats cancel and beats expiry (no pulse, new deadline armed); cancel beats expiry (no pulse).
REQ-021 Deadline <= time_i at set: expires at the following edge, pulse two cycles after the set strobe cycle.
REQ-022 dirty_q set by any accepted set, cancel or expiry; cleared on entering SCAN.
REQ-023 FSM states IDLE, SCAN, WR_SETUP, WR_ACCESS; IDLE->SCAN when dirty_q.
REQ-024 SCAN: one timer per cycle, index 0..NR_TIMERS-1 (NR_TIMERS cycles), tracking min deadline over armed timers; none armed -> min = 64'hFFFF_FFFF_FFFF_FFFF.
REQ-025 State changes during SCAN set dirty_q again; current scan completes and a rescan follows.
REQ-026 SCAN end -> WR_SETUP.
REQ-027 WR_SETUP: PSEL=1, PENABLE=0, PWRITE=1, PADDR=CMP_ADDR, PWDATA=min; one cycle, then WR_ACCESS.
REQ-028 WR_ACCESS: PSEL=1, PENABLE=1, address/data held stable; stay until PREADY=1, then IDLE.
REQ-029 On PREADY with PSLVERR=0: programmed_q <= min. With PSLVERR=1: err_o set, programmed_q unchanged, dirty_q set (retry).
REQ-030 Outside WR_SETUP/WR_ACCESS: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
REQ-031 Equal minima: lowest index wins (irrelevant to value written, fixes scan determinism).

Reset
REQ-032 HRESET high: armed_q=0, deadline_q=0, expired_o=0, err_o=0, FSM=IDLE, programmed_q=0, all APB outputs 0, busy_o=0.
REQ-033 dirty_q resets to 1 so an initial write (all-ones) clears the timer's reset-state interrupt.
REQ-034 Reset mid-transfer aborts immediately; PSEL drops the next cycle, no completion expected.

Configuration
REQ-035 Macro ARIANE_TIMER_SCHED_SKIP_REDUNDANT_EN defined: at SCAN end, if min == programmed_q and err_o==0, go to IDLE without an APB transfer.
REQ-036 Macro undefined: every SCAN ends with an APB write, even if value unchanged.

Verification
REQ-037 Reset release, PREADY=1 -> first APB write PWDATA=64'hFFFF_FFFF_FFFF_FFFF to 12'h400, armed_o=0.
REQ-038 time_i=100; set id1=500, id2=300 -> write 300; time_i=300 -> expired_o=4'b0100 one cycle, next write 500.
REQ-039 set id0=50 with time_i=100 -> expired_o[0] pulse two cycles after strobe, armed_o[0]=0.
REQ-040 Same cycle set id3=900 and cancel id3 -> armed_o[3]=1, written min includes 900.
REQ-041 PREADY held low 5 cycles -> PSEL/PENABLE/PADDR/PWDATA stable throughout; PSLVERR=1 -> err_o=1, identical write retried.
REQ-042 With SKIP_REDUNDANT_EN: cancel a non-minimum timer -> scan runs, no PSEL assertion.
